gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter INIT, default 0, giving the binary count value loaded by reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port load_gray, input, WIDTH bits: the value to load, Gray-coded.
REQ-009 The block SHALL have port bin, output, WIDTH bits: the registered binary count.
REQ-010 The block SHALL have port gray, output, WIDTH bits: the registered Gray code of bin.
REQ-011 The block SHALL have port wrap, output, 1 bit: a registered pulse on count wrap-around.

Function
REQ-012 On each rising clk edge, priority SHALL be rst > load > en > hold.
REQ-013 With load=1 and rst=0: bin SHALL take the binary value of load_gray (bit MSB = g MSB; bit i = bin[i+1] XOR g[i]); gray SHALL take load_gray; wrap SHALL be 0. en and up are ignored.
REQ-014 With en=1, up=1, load=0 and rst=0: bin SHALL take (bin+1) mod 2^WIDTH.
REQ-015 With en=1, up=0, load=0 and rst=0: bin SHALL take (bin-1) mod 2^WIDTH.
REQ-016 gray SHALL equal next_bin XOR (next_bin >> 1), registered in the same edge as bin: zero-cycle skew between bin and gray, one-cycle latency from en/load.
REQ-017 wrap SHALL be 1 for exactly the cycle following an up-step from all-ones to 0, or a down-step from 0 to all-ones; otherwise wrap SHALL be 0.
REQ-018 With en=0, load=0 and rst=0: bin and gray SHALL hold, and wrap SHALL be 0.
REQ-019 Between any two consecutive enabled count steps, gray SHALL differ in exactly one bit, including across a wrap.
REQ-020 up SHALL be allowed to change on any cycle; the step direction SHALL follow the value of up sampled at that edge.
REQ-021 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-022 While rst=1 at a clk edge, bin SHALL become INIT mod 2^WIDTH, gray SHALL become INIT XOR (INIT >> 1), and wrap SHALL become 0, regardless of en and load.
REQ-023 A reset asserted mid-count SHALL take effect at the next edge with no partial update; counting SHALL resume from INIT on the first edge with rst=0 and en=1.
REQ-024 Before the first reset edge, outputs are undefined; the bench SHALL assert rst for at least one edge before checking.

Verification (WIDTH=4, INIT=0 unless noted)
REQ-025 Reset: rst=1 for 2 cycles with en=1 and load=1 -> bin=0000, gray=0000, wrap=0.
REQ-026 Up sweep: en=1, up=1 for 16 cycles from 0 -> gray goes 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000; wrap=1 only with the final 0000; exactly one bit toggles per step.
REQ-027 Down wrap: from 0, en=1, up=0 for 1 cycle -> bin=1111, gray=1000, wrap=1; next down step -> bin=1110, gray=1001, wrap=0.
REQ-028 Load priority: load=1, load_gray=1101, en=1, up=1 -> bin=1001, gray=1101, wrap=0; with load=1 and load_gray=1000 while bin=1111 -> no wrap pulse.
REQ-029 Hold and mid-reset: at bin=0110, en=0 for 3 cycles -> bin=0110, gray=0101 held; then rst=1 with en=1 -> bin=0000, gray=0000.
REQ-030 Parameter sweep: WIDTH=8, INIT=8'hFF, reset then one up-step -> bin=00, gray=00, wrap=1; after reset, gray=8'h80.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary+Gray counter with Gray-coded load; bin, gray and wrap are all registered.
// One-cycle latency from en/load; no backpressure, a step is taken on every edge with en=1.
module gray_counter #(
    parameter int          WIDTH = 4,
    parameter logic [31:0] INIT  = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] INIT_BIN  = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Load takes priority over counting; reset priority is applied in the register block.
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = gray2bin(load_gray);
            gray_d = load_gray;
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + 1'b1;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - 1'b1;
                wrap_d = (bin_q == '0);
            end
            gray_d = bin_d ^ (bin_d >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboarded bench for gray_counter: a 4-bit default instance and an 8-bit INIT=FF instance.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] load_gray;
    logic [3:0] bin, gray;
    logic       wrap;

    logic       rst8, en8, up8, load8;
    logic [7:0] load_gray8;
    logic [7:0] bin8, gray8;
    logic       wrap8;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic       w;
        logic       stepped;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_bin;
    logic [3:0] prev_gray;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .bin(bin), .gray(gray), .wrap(wrap)
    );

    gray_counter #(.WIDTH(8), .INIT(32'hFF)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8),
        .load_gray(load_gray8), .bin(bin8), .gray(gray8), .wrap(wrap8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] g2b_model(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = g[3] ^ g[2];
        b[1] = g[3] ^ g[2] ^ g[1];
        b[0] = g[3] ^ g[2] ^ g[1] ^ g[0];
        return b;
    endfunction

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic u,
                        input logic l, input logic [3:0] lg);
        exp_t x;
        exp_t o;
        rst = r; en = e; up = u; load = l; load_gray = lg;
        x.w = 1'b0;
        x.stepped = 1'b0;
        if (r)      x.b = 4'd0;
        else if (l) x.b = g2b_model(lg);
        else if (e) begin
            x.b = u ? m_bin + 4'd1 : m_bin - 4'd1;
            x.w = u ? (m_bin == 4'hF) : (m_bin == 4'h0);
            x.stepped = 1'b1;
        end else    x.b = m_bin;
        x.g = x.b ^ (x.b >> 1);
        m_bin = x.b;
        sb_q.push_back(x);
        prev_gray = gray;
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        chk({tag, ".bin"},  bin,  o.b);
        chk({tag, ".gray"}, gray, o.g);
        chk({tag, ".wrap"}, wrap, o.w);
        if (o.stepped)
            chk({tag, ".onebit"}, $countones(prev_gray ^ gray), 1);
    endtask

    logic [3:0] sweep_gray [16];

    initial begin
        sweep_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                       4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        m_bin = 4'd0;
        rst8 = 1'b0; en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_gray8 = 8'h00;

        // Reset with en and load both asserted
        step("rst0", 1, 1, 1, 1, 4'hF);
        step("rst1", 1, 1, 1, 1, 4'hF);
        chk("rst.const", {bin, gray, wrap}, 9'b0);

        // Full up sweep, compared against the literal Gray sequence as well
        for (int i = 0; i < 16; i++) begin
            step("up", 0, 1, 1, 0, 4'h0);
            chk("up.table", gray, sweep_gray[i]);
            chk("up.wrap_const", wrap, (i == 15));
        end

        // Down step across zero, then one more
        step("dn_wrap", 0, 1, 0, 0, 4'h0);
        chk("dn_wrap.const", {bin, gray, wrap}, {4'b1111, 4'b1000, 1'b1});
        step("dn_next", 0, 1, 0, 0, 4'h0);
        chk("dn_next.const", {bin, gray, wrap}, {4'b1110, 4'b1001, 1'b0});

        // Load beats count; loading onto all-ones never pulses wrap
        step("ld1101", 0, 1, 1, 1, 4'b1101);
        chk("ld1101.const", {bin, gray, wrap}, {4'b1001, 4'b1101, 1'b0});
        step("ld1000a", 0, 1, 1, 1, 4'b1000);
        step("ld1000b", 0, 1, 1, 1, 4'b1000);
        chk("ld1000b.const", {bin, wrap}, {4'b1111, 1'b0});

        // Hold at 0110, then reset mid-count and resume
        step("ld0101", 0, 0, 1, 1, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            step("hold", 0, 0, 1, 0, 4'h0);
            chk("hold.const", {bin, gray}, {4'b0110, 4'b0101});
        end
        step("midrst", 1, 1, 1, 0, 4'h0);
        chk("midrst.const", {bin, gray}, 8'h00);
        step("resume", 0, 1, 1, 0, 4'h0);

        // Randomised direction changes, enables and occasional loads
        for (int i = 0; i < 60; i++) begin
            logic [3:0] lg;
            lg = 4'($urandom_range(0, 15));
            step("rand", 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), lg);
        end

        // 8-bit instance with INIT = 8'hFF
        rst8 = 1'b1; en8 = 1'b1; load8 = 1'b0;
        @(posedge clk); #1;
        chk("w8.rst.bin",  bin8,  8'hFF);
        chk("w8.rst.gray", gray8, 8'h80);
        chk("w8.rst.wrap", wrap8, 1'b0);
        rst8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
        @(posedge clk); #1;
        chk("w8.up.bin",  bin8,  8'h00);
        chk("w8.up.gray", gray8, 8'h00);
        chk("w8.up.wrap", wrap8, 1'b1);
        en8 = 1'b0;
        @(posedge clk); #1;
        chk("w8.hold.wrap", wrap8, 1'b0);
        chk("w8.hold.bin",  bin8,  8'h00);

        chk("sb.empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
